// File: rtl/mult_hilo_pkg.sv
// ============================================================================
// Module  : mult_hilo_pkg
// Purpose : Shared widths and FSM state encoding for the HI/LO multiply unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mult_hilo_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_wait_counter.sv
// ============================================================================
// Module  : mult_wait_counter
// Purpose : Wait-cycle counter; o_tc marks the last permitted wait cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_wait_counter #(
  parameter int TERMINAL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int c_CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

  // Terminal count is flagged during the TERMINAL-th enabled cycle.
  assign o_tc = i_en && (r_count == c_CNT_W'(TERMINAL - 1));

endmodule

`default_nettype wire

// File: rtl/mult_hilo_unit.sv
// ============================================================================
// Module  : mult_hilo_unit
// Purpose : HI/LO register file fronting an external 32x32 unsigned multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_hilo_unit
  import mult_hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [c_DATA_W-1:0] op_a,
  input  logic [c_DATA_W-1:0] op_b,
  output logic [c_DATA_W-1:0] mult_a,
  output logic [c_DATA_W-1:0] mult_b,
  output logic                mult_start,
  input  logic                mult_done,
  input  logic [c_PROD_W-1:0] mult_product,
  input  logic                mfhi,
  input  logic                mflo,
  input  logic                mthi,
  input  logic                mtlo,
  input  logic [c_DATA_W-1:0] wdata,
  output logic [c_DATA_W-1:0] rdata,
  output logic [c_DATA_W-1:0] hi,
  output logic [c_DATA_W-1:0] lo,
  output logic                busy,
  output logic                stall,
  output logic                err
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_cnt_clr;
  logic                w_cnt_en;
  logic                w_cnt_tc;
  logic                w_load_prod;
  logic                w_timeout;
  logic                w_idle;
  logic                w_req;
  logic [c_DATA_W-1:0] r_mult_a;
  logic [c_DATA_W-1:0] r_mult_b;
  logic [c_DATA_W-1:0] r_hi;
  logic [c_DATA_W-1:0] r_lo;
  logic                r_err;

  mult_wait_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_load_prod = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_cnt_en = 1'b1;
        // A completion in the final permitted cycle still wins over the timeout.
        if (mult_done) begin
          w_load_prod = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_cnt_tc) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_idle = (r_state == IDLE);
  assign w_req  = start | mfhi | mflo | mthi | mtlo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mult_a <= '0;
      r_mult_b <= '0;
    end else if (w_idle && start) begin
      r_mult_a <= op_a;
      r_mult_b <= op_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_load_prod) begin
      r_hi <= mult_product[c_PROD_W-1:c_DATA_W];
      r_lo <= mult_product[c_DATA_W-1:0];
    end else if (w_idle) begin
      if (mthi) r_hi <= wdata;
      if (mtlo) r_lo <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (w_idle) begin
      if (mfhi) begin
        rdata = r_hi;
      end else if (mflo) begin
        rdata = r_lo;
      end
    end
  end

  assign busy       = ~w_idle;
  assign stall      = busy & w_req;
  assign mult_start = (r_state == ISSUE);
  assign mult_a     = r_mult_a;
  assign mult_b     = r_mult_b;
  assign hi         = r_hi;
  assign lo         = r_lo;
  assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mult_hilo_unit.sv
// ============================================================================
// Module  : tb_mult_hilo_unit
// Purpose : Self-checking bench for mult_hilo_unit against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_hilo_unit;

  logic        clk;
  logic        rst;
  logic        start, mfhi, mflo, mthi, mtlo, mult_done;
  logic [31:0] op_a, op_b, wdata;
  logic [63:0] mult_product;
  logic [31:0] mult_a, mult_b, rdata, hi, lo;
  logic        mult_start, busy, stall, err;

  logic        t_start, t_mfhi, t_mflo, t_mthi, t_mtlo, t_done;
  logic [31:0] t_op_a, t_op_b, t_wdata;
  logic [63:0] t_product;
  logic [31:0] t_mult_a, t_mult_b, t_rdata, t_hi, t_lo;
  logic        t_mult_start, t_busy, t_stall, t_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;

  mult_hilo_unit dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
    .mult_done(mult_done), .mult_product(mult_product),
    .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .rdata(rdata), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .err(err)
  );

  mult_hilo_unit #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst(rst), .start(t_start), .op_a(t_op_a), .op_b(t_op_b),
    .mult_a(t_mult_a), .mult_b(t_mult_b), .mult_start(t_mult_start),
    .mult_done(t_done), .mult_product(t_product),
    .mfhi(t_mfhi), .mflo(t_mflo), .mthi(t_mthi), .mtlo(t_mtlo), .wdata(t_wdata),
    .rdata(t_rdata), .hi(t_hi), .lo(t_lo), .busy(t_busy), .stall(t_stall), .err(t_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full multiply on dut, acting as the downstream multiplier.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int lat,
                          output int t_issue, output logic [31:0] ma, output logic [31:0] mb);
    op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    t_issue = -1;
    for (int i = 0; i < 4; i++) begin
      if (mult_start) begin
        t_issue = i + 1;
        break;
      end
      step();
    end
    ma = mult_a; mb = mult_b;
    step();
    repeat (lat) step();
    mult_product = {32'd0, ma} * {32'd0, mb};
    mult_done = 1'b1;
    step();
    mult_done = 1'b0;
    mult_product = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mfhi = 1'b1; mthi = 1'b1; wdata = 32'hA5A5A5A5;
    step(); step();
    checks++; if (busy !== 1'b0 || stall !== 1'b0 || mult_start !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: busy=%b stall=%b mstart=%b err=%b expected all 0", busy, stall, mult_start, err);
    end
    checks++; if (hi !== 32'd0 || lo !== 32'd0 || mult_a !== 32'd0 || mult_b !== 32'd0) begin
      errors++; $display("FAIL reset_regs: hi=%h lo=%h ma=%h mb=%h expected 0", hi, lo, mult_a, mult_b);
    end
    start = 1'b0; mfhi = 1'b0; mthi = 1'b0;
    rst = 1'b0;
    step();
    m_hi = 32'd0; m_lo = 32'd0;
    checks++; if (rdata !== 32'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL idle_noreq: rdata=%h stall=%b expected 0/0", rdata, stall);
    end
  endtask

  task automatic test_basic();
    int ti; logic [31:0] ma, mb;
    run_mult(32'd3, 32'd5, 31, ti, ma, mb);
    checks++; if (ti !== 1) begin
      errors++; $display("FAIL basic_issue: mult_start at cycle %0d expected 1", ti);
    end
    checks++; if (hi !== 32'h0 || lo !== 32'hF || busy !== 1'b0) begin
      errors++; $display("FAIL basic_3x5: hi=%h lo=%h busy=%b expected 0/f/0", hi, lo, busy);
    end
    m_hi = 32'h0; m_lo = 32'hF;
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 0, ti, ma, mb);
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++; $display("FAIL max_operands: hi=%h lo=%h expected fffffffe/00000001", hi, lo);
    end
    m_hi = 32'hFFFFFFFE; m_lo = 32'h1;
  endtask

  task automatic test_random_back_to_back();
    int ti; logic [31:0] a, b, ma, mb; logic [63:0] p;
    for (int n = 0; n < 12; n++) begin
      a = $urandom; b = $urandom;
      if (n == 0) a = 32'd0;
      run_mult(a, b, $urandom_range(0, 20), ti, ma, mb);
      p = {32'd0, a} * {32'd0, b};
      m_hi = p[63:32]; m_lo = p[31:0];
      checks++; if (ma !== a || mb !== b || ti !== 1) begin
        errors++; $display("FAIL rand_issue%0d: ma=%h mb=%h cyc=%0d expected %h %h 1", n, ma, mb, ti, a, b);
      end
      checks++; if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
        errors++; $display("FAIL rand_prod%0d: hi=%h lo=%h busy=%b expected %h %h 0", n, hi, lo, busy, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_stall_and_ignore();
    logic [31:0] a, b; logic [63:0] p;
    mult_done = 1'b1; mult_product = {$urandom, $urandom};
    step();
    mult_done = 1'b0;
    checks++; if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      errors++; $display("FAIL done_in_idle: hi=%h lo=%h busy=%b expected %h %h 0", hi, lo, busy, m_hi, m_lo);
    end
    a = $urandom; b = $urandom;
    op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0;
    mult_done = 1'b1; mult_product = {$urandom, $urandom};
    step();
    mult_done = 1'b0;
    checks++; if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL done_in_issue: busy=%b hi=%h lo=%h expected 1 %h %h", busy, hi, lo, m_hi, m_lo);
    end
    mfhi = 1'b1; #1;
    checks++; if (stall !== 1'b1 || rdata !== 32'd0) begin
      errors++; $display("FAIL read_busy: stall=%b rdata=%h expected 1/0", stall, rdata);
    end
    mfhi = 1'b0; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h12345678; start = 1'b1; op_a = $urandom; #1;
    checks++; if (stall !== 1'b1) begin
      errors++; $display("FAIL write_busy_stall: stall=%b expected 1", stall);
    end
    step();
    mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
    checks++; if (hi !== m_hi || lo !== m_lo || mult_a !== a || mult_b !== b) begin
      errors++; $display("FAIL write_busy_ignored: hi=%h lo=%h ma=%h expected %h %h %h", hi, lo, mult_a, m_hi, m_lo, a);
    end
    p = {32'd0, a} * {32'd0, b};
    mult_product = p; mult_done = 1'b1;
    step();
    mult_done = 1'b0;
    m_hi = p[63:32]; m_lo = p[31:0];
    mfhi = 1'b1; #1;
    checks++; if (stall !== 1'b0 || rdata !== m_hi) begin
      errors++; $display("FAIL read_after_done: stall=%b rdata=%h expected 0 %h", stall, rdata, m_hi);
    end
    mfhi = 1'b0;
  endtask

  task automatic test_read_write();
    logic [31:0] v;
    mthi = 1'b1; wdata = 32'hDEADBEEF; mflo = 1'b1; #1;
    checks++; if (rdata !== m_lo || stall !== 1'b0) begin
      errors++; $display("FAIL rw_same_cycle: rdata=%h stall=%b expected %h 0", rdata, stall, m_lo);
    end
    step();
    mthi = 1'b0; mflo = 1'b0;
    m_hi = 32'hDEADBEEF;
    checks++; if (hi !== 32'hDEADBEEF || lo !== m_lo) begin
      errors++; $display("FAIL mthi_write: hi=%h lo=%h expected deadbeef %h", hi, lo, m_lo);
    end
    v = $urandom;
    mthi = 1'b1; mtlo = 1'b1; wdata = v;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    m_hi = v; m_lo = v;
    v = $urandom;
    mtlo = 1'b1; wdata = v;
    step();
    mtlo = 1'b0; m_lo = v;
    mfhi = 1'b1; mflo = 1'b1; #1;
    checks++; if (rdata !== m_hi) begin
      errors++; $display("FAIL mfhi_priority: rdata=%h expected %h", rdata, m_hi);
    end
    mfhi = 1'b0; #1;
    checks++; if (rdata !== m_lo) begin
      errors++; $display("FAIL mflo_read: rdata=%h expected %h", rdata, m_lo);
    end
    mflo = 1'b0;
  endtask

  task automatic test_start_with_write();
    logic [31:0] a, b, v; logic [63:0] p;
    a = $urandom; b = $urandom; v = $urandom;
    op_a = a; op_b = b; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = v;
    step();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++; if (hi !== v || lo !== v || busy !== 1'b1) begin
      errors++; $display("FAIL start_write_now: hi=%h lo=%h busy=%b expected %h %h 1", hi, lo, busy, v, v);
    end
    step(); step();
    p = {32'd0, a} * {32'd0, b};
    mult_product = p; mult_done = 1'b1;
    step();
    mult_done = 1'b0;
    m_hi = p[63:32]; m_lo = p[31:0];
    checks++; if (hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL start_write_prod: hi=%h lo=%h expected %h %h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid_op();
    op_a = $urandom | 32'd1; op_b = $urandom | 32'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mult_a !== 32'd0) begin
      errors++; $display("FAIL async_reset: busy=%b hi=%h lo=%h ma=%h expected 0", busy, hi, lo, mult_a);
    end
    step();
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    mult_product = {$urandom, $urandom}; mult_done = 1'b1;
    step();
    mult_done = 1'b0;
    checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL done_after_reset: hi=%h lo=%h busy=%b err=%b expected 0", hi, lo, busy, err);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] v, a, b; logic [63:0] p;
    v = $urandom;
    t_mthi = 1'b1; t_mtlo = 1'b1; t_wdata = v;
    step();
    t_mthi = 1'b0; t_mtlo = 1'b0;
    a = $urandom; b = $urandom; p = {32'd0, a} * {32'd0, b};
    t_op_a = a; t_op_b = b; t_start = 1'b1;
    step();
    t_start = 1'b0;
    step();
    repeat (7) step();
    t_product = p; t_done = 1'b1;
    step();
    t_done = 1'b0;
    checks++; if (t_hi !== p[63:32] || t_lo !== p[31:0] || t_err !== 1'b0 || t_busy !== 1'b0) begin
      errors++; $display("FAIL done_last_cycle: hi=%h lo=%h err=%b expected %h %h 0", t_hi, t_lo, t_err, p[63:32], p[31:0]);
    end
    t_mthi = 1'b1; t_mtlo = 1'b1; t_wdata = v;
    step();
    t_mthi = 1'b0; t_mtlo = 1'b0;
    t_start = 1'b1;
    step();
    t_start = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++; if (t_busy !== 1'b1 || t_err !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d: busy=%b err=%b expected 1/0", i, t_busy, t_err);
      end
      step();
    end
    checks++; if (t_err !== 1'b1 || t_busy !== 1'b0 || t_hi !== v || t_lo !== v) begin
      errors++; $display("FAIL timeout: err=%b busy=%b hi=%h lo=%h expected 1 0 %h %h", t_err, t_busy, t_hi, t_lo, v, v);
    end
    t_done = 1'b1; t_product = {$urandom, $urandom};
    step(); step();
    t_done = 1'b0;
    checks++; if (t_err !== 1'b1 || t_hi !== v) begin
      errors++; $display("FAIL err_sticky: err=%b hi=%h expected 1 %h", t_err, t_hi, v);
    end
    rst = 1'b1; #1;
    checks++; if (t_err !== 1'b0) begin
      errors++; $display("FAIL err_reset: err=%b expected 0", t_err);
    end
    step();
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  initial begin
    start = 0; mfhi = 0; mflo = 0; mthi = 0; mtlo = 0; mult_done = 0;
    op_a = 0; op_b = 0; wdata = 0; mult_product = 0;
    t_start = 0; t_mfhi = 0; t_mflo = 0; t_mthi = 0; t_mtlo = 0; t_done = 0;
    t_op_a = 0; t_op_b = 0; t_wdata = 0; t_product = 0;
    rst = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_random_back_to_back();
    test_stall_and_ignore();
    test_read_write();
    test_start_with_write();
    test_reset_mid_op();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
